// File: rtl/sram_pkg.sv
// Shared types and constants for the async SRAM controller and its pin-level ports.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    WR    = 2'd2,
    WHOLD = 2'd3
  } sram_state_t;

  localparam int EXT_SEL_BIT = 22;
  localparam int SRAM_AW     = 20;

endpackage

// File: rtl/sram_port.sv
// One SRAM chip's registered control pins and tristate data buffer.
// Every pin and the bus drive enable come straight from a flop.
module sram_port
  import sram_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               ce_n_i,
  input  logic               oe_n_i,
  input  logic               we_n_i,
  input  logic               drive_i,
  input  logic [3:0]         be_n_i,
  input  logic [SRAM_AW-1:0] addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        din_o,
  inout  wire  [31:0]        ram_data_io,
  output logic [SRAM_AW-1:0] ram_addr_o,
  output logic [3:0]         ram_be_n_o,
  output logic               ram_ce_n_o,
  output logic               ram_oe_n_o,
  output logic               ram_we_n_o
);

  logic               ce_n_q;
  logic               oe_n_q;
  logic               we_n_q;
  logic               drive_q;
  logic [3:0]         be_n_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [31:0]        wdata_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      drive_q <= 1'b0;
      be_n_q  <= 4'hF;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      ce_n_q  <= ce_n_i;
      oe_n_q  <= oe_n_i;
      we_n_q  <= we_n_i;
      drive_q <= drive_i;
      // Byte lanes stay disabled whenever the chip is deselected.
      be_n_q  <= ce_n_i ? 4'hF : be_n_i;
      if (!ce_n_i) addr_q <= addr_i;
      if (drive_i) wdata_q <= wdata_i;
    end
  end

  assign ram_data_io = drive_q ? wdata_q : 32'hzzzz_zzzz;
  assign din_o       = ram_data_io;
  assign ram_addr_o  = addr_q;
  assign ram_be_n_o  = be_n_q;
  assign ram_ce_n_o  = ce_n_q;
  assign ram_oe_n_o  = oe_n_q;
  assign ram_we_n_o  = we_n_q;

endmodule

// File: rtl/sram_ctrl.sv
// Single-request word controller for BaseRAM/ExtRAM with programmable read/write wait states.
// Pin values are computed from the next state so they land in flops inside sram_port.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  input  logic [3:0]         req_be,
  output logic               resp_valid,
  output logic [31:0]        resp_rdata,
  inout  wire  [31:0]        base_ram_data,
  output logic [SRAM_AW-1:0] base_ram_addr,
  output logic [3:0]         base_ram_be_n,
  output logic               base_ram_ce_n,
  output logic               base_ram_oe_n,
  output logic               base_ram_we_n,
  inout  wire  [31:0]        ext_ram_data,
  output logic [SRAM_AW-1:0] ext_ram_addr,
  output logic [3:0]         ext_ram_be_n,
  output logic               ext_ram_ce_n,
  output logic               ext_ram_oe_n,
  output logic               ext_ram_we_n
);

  localparam int MAXW = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CW   = $clog2(MAXW + 1);

  sram_state_t        state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               we_q, we_d;
  logic               ext_q, ext_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic               resp_valid_q, resp_valid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        base_din, ext_din;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:EXT_SEL_BIT+1], req_addr[1:0]};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    ext_d        = ext_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    resp_valid_d = 1'b0;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          ext_d   = req_addr[EXT_SEL_BIT];
          addr_d  = req_addr[SRAM_AW+1:2];
          wdata_d = req_wdata;
          be_d    = req_be;
          state_d = req_we ? WR : RD;
          cnt_d   = req_we ? CW'(WR_WAIT - 1) : CW'(RD_WAIT - 1);
        end
      end
      RD: begin
        if (cnt_q == '0) begin
          // Last strobe cycle: SRAM output has had the full wait to settle.
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          rdata_d      = ext_q ? ext_din : base_din;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WR: begin
        if (cnt_q == '0) state_d = WHOLD;
        else cnt_d = cnt_q - CW'(1);
      end
      WHOLD: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  logic [1:0] sel_d;
  logic [1:0] ce_n_d, oe_n_d, we_n_d, drive_d;
  logic [3:0] be_n_d;

  assign sel_d  = {ext_d, ~ext_d};
  assign be_n_d = we_d ? ~be_d : 4'h0;

  // The accept cycle (IDLE) never strobes, so read and write drive are never adjacent.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_pin
      assign ce_n_d[gi]  = !(sel_d[gi] && (state_d != IDLE));
      assign oe_n_d[gi]  = !(sel_d[gi] && (state_d == RD));
      assign we_n_d[gi]  = !(sel_d[gi] && (state_d == WR));
      assign drive_d[gi] = sel_d[gi] && ((state_d == WR) || (state_d == WHOLD));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      ext_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      ext_q        <= ext_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;

  sram_port u_base (
    .clk         (clk),
    .rstn        (rstn),
    .ce_n_i      (ce_n_d[0]),
    .oe_n_i      (oe_n_d[0]),
    .we_n_i      (we_n_d[0]),
    .drive_i     (drive_d[0]),
    .be_n_i      (be_n_d),
    .addr_i      (addr_d),
    .wdata_i     (wdata_d),
    .din_o       (base_din),
    .ram_data_io (base_ram_data),
    .ram_addr_o  (base_ram_addr),
    .ram_be_n_o  (base_ram_be_n),
    .ram_ce_n_o  (base_ram_ce_n),
    .ram_oe_n_o  (base_ram_oe_n),
    .ram_we_n_o  (base_ram_we_n)
  );

  sram_port u_ext (
    .clk         (clk),
    .rstn        (rstn),
    .ce_n_i      (ce_n_d[1]),
    .oe_n_i      (oe_n_d[1]),
    .we_n_i      (we_n_d[1]),
    .drive_i     (drive_d[1]),
    .be_n_i      (be_n_d),
    .addr_i      (addr_d),
    .wdata_i     (wdata_d),
    .din_o       (ext_din),
    .ram_data_io (ext_ram_data),
    .ram_addr_o  (ext_ram_addr),
    .ram_be_n_o  (ext_ram_be_n),
    .ram_ce_n_o  (ext_ram_ce_n),
    .ram_oe_n_o  (ext_ram_oe_n),
    .ram_we_n_o  (ext_ram_we_n)
  );

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: both SRAMs modelled as async memories, request-level reference memory,
// plus a second instance built with RD_WAIT=1, WR_WAIT=4 for latency checks.
module tb_sram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        req_ready, resp_valid;
  logic [31:0] resp_rdata;
  wire  [31:0] base_ram_data, ext_ram_data;
  logic [19:0] base_ram_addr, ext_ram_addr;
  logic [3:0]  base_ram_be_n, ext_ram_be_n;
  logic        base_ram_ce_n, base_ram_oe_n, base_ram_we_n;
  logic        ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n;

  sram_ctrl dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .base_ram_data(base_ram_data), .base_ram_addr(base_ram_addr),
    .base_ram_be_n(base_ram_be_n), .base_ram_ce_n(base_ram_ce_n), .base_ram_oe_n(base_ram_oe_n),
    .base_ram_we_n(base_ram_we_n), .ext_ram_data(ext_ram_data), .ext_ram_addr(ext_ram_addr),
    .ext_ram_be_n(ext_ram_be_n), .ext_ram_ce_n(ext_ram_ce_n), .ext_ram_oe_n(ext_ram_oe_n),
    .ext_ram_we_n(ext_ram_we_n)
  );

  logic        d2_valid = 1'b0, d2_we = 1'b0;
  logic [31:0] d2_addr = '0, d2_wdata = '0;
  logic [3:0]  d2_be = '0;
  logic        d2_ready, d2_resp;
  logic [31:0] d2_rdata;
  wire  [31:0] d2_bdata, d2_edata;
  logic [19:0] d2_baddr, d2_eaddr;
  logic [3:0]  d2_bbe, d2_ebe;
  logic        d2_bce, d2_boe, d2_bwe, d2_ece, d2_eoe, d2_ewe;

  sram_ctrl #(.RD_WAIT(1), .WR_WAIT(4)) dut2 (
    .clk(clk), .rstn(rstn), .req_valid(d2_valid), .req_ready(d2_ready), .req_we(d2_we),
    .req_addr(d2_addr), .req_wdata(d2_wdata), .req_be(d2_be), .resp_valid(d2_resp),
    .resp_rdata(d2_rdata), .base_ram_data(d2_bdata), .base_ram_addr(d2_baddr),
    .base_ram_be_n(d2_bbe), .base_ram_ce_n(d2_bce), .base_ram_oe_n(d2_boe),
    .base_ram_we_n(d2_bwe), .ext_ram_data(d2_edata), .ext_ram_addr(d2_eaddr),
    .ext_ram_be_n(d2_ebe), .ext_ram_ce_n(d2_ece), .ext_ram_oe_n(d2_eoe),
    .ext_ram_we_n(d2_ewe)
  );

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // SRAM chip models (index 0 = BaseRAM, 1 = ExtRAM) and the request-level reference memory
  logic [31:0] sram_mem [2][256];
  logic [31:0] ref_mem  [2][256];
  logic        probe_en = 1'b0;
  logic [31:0] probe_val = '0;

  wire [1:0]  ce_v = {ext_ram_ce_n, base_ram_ce_n};
  wire [1:0]  oe_v = {ext_ram_oe_n, base_ram_oe_n};
  wire [1:0]  we_v = {ext_ram_we_n, base_ram_we_n};
  wire [19:0] addr_v [2];
  wire [3:0]  be_v [2];
  wire [31:0] bus_v [2];
  assign addr_v[0] = base_ram_addr;
  assign addr_v[1] = ext_ram_addr;
  assign be_v[0]   = base_ram_be_n;
  assign be_v[1]   = ext_ram_be_n;
  assign bus_v[0]  = base_ram_data;
  assign bus_v[1]  = ext_ram_data;

  wire        b_en  = probe_en | (!base_ram_ce_n & !base_ram_oe_n);
  wire        e_en  = probe_en | (!ext_ram_ce_n & !ext_ram_oe_n);
  wire [31:0] b_val = probe_en ? probe_val : sram_mem[0][base_ram_addr[7:0]];
  wire [31:0] e_val = probe_en ? probe_val : sram_mem[1][ext_ram_addr[7:0]];
  assign base_ram_data = b_en ? b_val : 32'hzzzz_zzzz;
  assign ext_ram_data  = e_en ? e_val : 32'hzzzz_zzzz;

  logic        mon_en = 1'b0;
  int          ce_low [2];
  int          we_low [2];
  logic [19:0] last_addr [2];
  logic [3:0]  last_be [2];
  logic        prev_fpga [2];

  always @(negedge clk) begin
    if (mon_en) begin
      for (int c = 0; c < 2; c++) begin
        if (!ce_v[c]) begin
          ce_low[c]    <= ce_low[c] + 1;
          last_addr[c] <= addr_v[c];
          last_be[c]   <= be_v[c];
        end
        if (!we_v[c]) begin
          we_low[c] <= we_low[c] + 1;
          if (!ce_v[c])
            for (int b = 0; b < 4; b++)
              if (!be_v[c][b]) sram_mem[c][addr_v[c][7:0]][8*b +: 8] <= bus_v[c][8*b +: 8];
        end
        if (!oe_v[c]) begin
          chk("rd_turnaround", {31'b0, prev_fpga[c] | ~we_v[c]}, 32'h0);
          chk("rd_bus", bus_v[c], sram_mem[c][addr_v[c][7:0]]);
        end else if (!ce_v[c]) begin
          chk("wr_bus_known", {31'b0, $isunknown(bus_v[c])}, 32'h0);
        end
        prev_fpga[c] <= !ce_v[c] && oe_v[c];
      end
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mk_addr(input logic ext, input int word);
    logic [31:0] a;
    a = $urandom;
    a[22] = ext;
    a[21:2] = 20'(word);
    return a;
  endfunction

  task automatic clr_stats();
    for (int c = 0; c < 2; c++) begin
      ce_low[c] = 0;
      we_low[c] = 0;
    end
  endtask

  task automatic probe_bus(input string tag, input logic [31:0] v);
    probe_val = v;
    probe_en = 1'b1;
    #1;
    chk({tag, "_base_bus"}, base_ram_data, v);
    chk({tag, "_ext_bus"}, ext_ram_data, v);
    probe_en = 1'b0;
  endtask

  // Issues one request from a negedge, returns latency (cycles from accept to resp_valid).
  task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, output int lat, output logic [31:0] rd);
    int   w;
    logic c;
    c = a[22];
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    chk("accept_wait", {31'b0, req_ready}, 32'h1);
    clr_stats();
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom_range(0, 15));
    lat = 1;
    while (!resp_valid && lat < 50) begin @(negedge clk); lat++; end
    rd = resp_rdata;
    if (we) ref_mem[c][a[9:2]] = merge(ref_mem[c][a[9:2]], wd, be);
    $display("txn %s chip=%0d word=%0d be=%h wdata=%h rdata=%h lat=%0d",
             we ? "WR" : "RD", c, a[21:2], be, wd, rd, lat);
  endtask

  logic        rq_we [3];
  logic [31:0] rq_a [3];
  logic [31:0] rq_d [3];
  logic [3:0]  rq_be [3];

  task automatic load_req(input int k);
    req_we = rq_we[k]; req_addr = rq_a[k]; req_wdata = rq_d[k]; req_be = rq_be[k];
  endtask

  initial begin
    int          lat, na, nr, cyc, wl, x, y;
    bit          pend;
    logic [31:0] rd, a, old, e0, e2, exp, wd;
    logic [3:0]  be;
    logic        we;
    int          acc [3];
    int          rt [3];
    logic [31:0] rdv [3];

    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 256; i++) begin
        old = $urandom;
        sram_mem[c][i] = old;
        ref_mem[c][i]  = old;
      end
    for (int c = 0; c < 2; c++) prev_fpga[c] = 1'b0;
    clr_stats();

    // 1. reset and idle
    repeat (3) @(negedge clk);
    chk("rst_ctl_pins", {26'b0, ce_v, oe_v, we_v}, 32'h3F);
    chk("rst_be_n", {24'b0, base_ram_be_n, ext_ram_be_n}, 32'hFF);
    chk("rst_base_addr", {12'b0, base_ram_addr}, 32'h0);
    chk("rst_ext_addr", {12'b0, ext_ram_addr}, 32'h0);
    chk("rst_ready_resp", {30'b0, req_ready, resp_valid}, 32'h2);
    chk("rst_rdata", resp_rdata, 32'h0);
    probe_bus("rst", 32'hA5C3_961E);
    rstn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_ctl_pins", {26'b0, ce_v, oe_v, we_v}, 32'h3F);
    chk("idle_ready_resp", {30'b0, req_ready, resp_valid}, 32'h2);
    probe_bus("idle", 32'h5A3C_69E1);
    mon_en = 1'b1;

    // 2. full-word write then read, BaseRAM
    a = 32'h0000_0010;
    xact(1'b1, a, 32'hDEAD_BEEF, 4'hF, lat, rd);
    chk("t2_wr_lat", lat, 32'd4);
    chk("t2_base_addr", {12'b0, last_addr[0]}, 32'd4);
    chk("t2_we_low_cycles", we_low[0], 32'd2);
    chk("t2_wr_ext_untouched", ce_low[1], 32'd0);
    xact(1'b0, a, 32'h0, 4'h0, lat, rd);
    chk("t2_rd_lat", lat, 32'd3);
    chk("t2_rdata", rd, 32'hDEAD_BEEF);
    chk("t2_rd_ext_untouched", ce_low[1], 32'd0);

    // 3. partial write to ExtRAM
    a = 32'h0040_0008;
    old = ref_mem[1][2];
    xact(1'b1, a, 32'h0000_AB00, 4'b0010, lat, rd);
    chk("t3_ext_be_n", {28'b0, last_be[1]}, 32'hD);
    chk("t3_ext_addr", {12'b0, last_addr[1]}, 32'd2);
    chk("t3_base_untouched", ce_low[0], 32'd0);
    xact(1'b0, a, 32'h0, 4'h0, lat, rd);
    chk("t3_rdata", rd, {old[31:16], 8'hAB, old[7:0]});

    // 4. back-to-back read / write / read with valid held high
    x = $urandom_range(0, 1);
    y = $urandom_range(0, 127);
    rq_we[0] = 1'b0; rq_a[0] = mk_addr(1'($urandom_range(0, 1)), $urandom_range(0, 127));
    rq_we[1] = 1'b1; rq_a[1] = mk_addr(1'(x), y);
    rq_we[2] = 1'b0; rq_a[2] = mk_addr(1'(x), y);
    for (int k = 0; k < 3; k++) begin rq_d[k] = $urandom; rq_be[k] = 4'($urandom_range(0, 15)); end
    e0 = ref_mem[rq_a[0][22]][rq_a[0][9:2]];
    ref_mem[x][y] = merge(ref_mem[x][y], rq_d[1], rq_be[1]);
    e2 = ref_mem[x][y];
    for (int k = 0; k < 3; k++) begin acc[k] = -100; rt[k] = -100; rdv[k] = '0; end
    na = 0; nr = 0; cyc = 0; pend = 0;
    load_req(0);
    req_valid = 1'b1;
    while (cyc < 40) begin
      if (na < 3 && req_valid && req_ready) begin
        acc[na] = cyc;
        $display("txn B2B%0d %s chip=%0d word=%0d be=%h wdata=%h", na, req_we ? "WR" : "RD",
                 req_addr[22], req_addr[21:2], req_be, req_wdata);
        na++;
        pend = 1;
      end
      @(negedge clk);
      cyc++;
      if (resp_valid && nr < 3) begin rt[nr] = cyc; rdv[nr] = resp_rdata; nr++; end
      if (pend) begin
        pend = 0;
        if (na < 3) load_req(na);
        else req_valid = 1'b0;
      end
    end
    chk("t4_accepts", na, 32'd3);
    chk("t4_resps", nr, 32'd3);
    chk("t4_gap_rd_wr", acc[1] - acc[0], 32'd3);
    chk("t4_gap_wr_rd", acc[2] - acc[1], 32'd4);
    chk("t4_accept_in_resp_cycle", acc[1], rt[0]);
    chk("t4_wr_resp_lat", rt[1] - acc[1], 32'd4);
    chk("t4_rdata0", rdv[0], e0);
    chk("t4_rdata2", rdv[2], e2);

    // randomized traffic against the reference memory
    for (int i = 0; i < 24; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = mk_addr(1'($urandom_range(0, 1)), $urandom_range(0, 127));
      wd = $urandom;
      be = 4'($urandom_range(0, 15));
      exp = ref_mem[a[22]][a[9:2]];
      xact(we, a, wd, be, lat, rd);
      chk("rand_lat", lat, we ? 32'd4 : 32'd3);
      if (!we) chk("rand_rdata", rd, exp);
    end

    // 5. reset in the first write strobe cycle aborts the access
    chk("t5_ready", {31'b0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = mk_addr(1'b0, 200);
    req_wdata = $urandom; req_be = 4'hF;
    $display("txn WR-ABORT chip=0 word=200 wdata=%h", req_wdata);
    @(negedge clk);
    req_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("t5_ctl_pins_after_rst", {26'b0, ce_v, oe_v, we_v}, 32'h3F);
    chk("t5_no_resp", {31'b0, resp_valid}, 32'h0);
    probe_bus("t5", 32'h3C96_A55A);
    @(negedge clk);
    chk("t5_no_resp_late", {31'b0, resp_valid}, 32'h0);
    a = mk_addr(1'b0, 7);
    exp = ref_mem[0][7];
    xact(1'b0, a, 32'h0, 4'h0, lat, rd);
    chk("t5_next_lat", lat, 32'd3);
    chk("t5_next_rdata", rd, exp);

    // 6. second build: RD_WAIT=1, WR_WAIT=4
    chk("t6_ready", {31'b0, d2_ready}, 32'h1);
    d2_valid = 1'b1; d2_we = 1'b0; d2_addr = mk_addr(1'b1, 5);
    @(negedge clk);
    d2_valid = 1'b0;
    lat = 1;
    while (!d2_resp && lat < 50) begin @(negedge clk); lat++; end
    $display("txn D2-RD chip=1 word=5 lat=%0d", lat);
    chk("t6_rd_lat", lat, 32'd2);
    d2_valid = 1'b1; d2_we = 1'b1; d2_be = 4'hF; d2_wdata = $urandom; d2_addr = mk_addr(1'b0, 9);
    @(negedge clk);
    d2_valid = 1'b0;
    lat = 1;
    wl = d2_bwe ? 0 : 1;
    while (!d2_resp && lat < 50) begin
      @(negedge clk);
      lat++;
      if (!d2_bwe) wl++;
    end
    $display("txn D2-WR chip=0 word=9 wdata=%h lat=%0d", d2_wdata, lat);
    chk("t6_wr_lat", lat, 32'd6);
    chk("t6_we_low_cycles", wl, 32'd4);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
